// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite loader: RGB565 colour key, the pink
// range that is folded onto the key, and the loader state encoding.
package sprite_pkg;

  // Transparent-colour key in RGB565 (magenta).
  localparam logic [15:0] KEY_RGB565 = 16'hF81F;

  // Pure white is also treated as "transparent" by the normalizer.
  localparam logic [23:0] WHITE_RGB888 = 24'hFFFFFF;

  // Pink-ish colours produced by anti-aliased artwork around the key.
  localparam logic [7:0] PINK_R_MIN = 8'hD8;
  localparam logic [7:0] PINK_G_MIN = 8'h90;
  localparam logic [7:0] PINK_G_MAX = 8'hB4;
  localparam logic [7:0] PINK_B_MIN = 8'hA8;
  localparam logic [7:0] PINK_B_MAX = 8'hCC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } load_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Truncating RGB888 -> RGB565 conversion (keeps the top bits of each channel).
  function automatic logic [15:0] to_rgb565(input rgb888_t p);
    return {p.r[7:3], p.g[7:2], p.b[7:3]};
  endfunction

endpackage

// File: rtl/rgb565_pack.sv
// Combinational RGB888 -> RGB565 packer.
// Optional feature: define SPRITE_KEY_NORMALIZE_EN to map white and the
// pink key range onto the RGB565 transparency key.
module rgb565_pack
  import sprite_pkg::*;
(
  input  logic [23:0] rgb,
  output logic [15:0] rgb565
);

  rgb888_t pix;
  assign pix = rgb888_t'(rgb);

`ifdef SPRITE_KEY_NORMALIZE_EN
  logic is_key;

  // Classify the pixel as transparent (white or within the pink range).
  always_comb begin
    is_key = (rgb == WHITE_RGB888) ||
             ((pix.r >= PINK_R_MIN) &&
              (pix.g >= PINK_G_MIN) && (pix.g <= PINK_G_MAX) &&
              (pix.b >= PINK_B_MIN) && (pix.b <= PINK_B_MAX));
  end

  // Emit the key for transparent pixels, the packed colour otherwise.
  always_comb begin
    rgb565 = is_key ? KEY_RGB565 : to_rgb565(pix);
  end
`else
  // Plain truncating pack.
  always_comb begin
    rgb565 = to_rgb565(pix);
  end
`endif

endmodule

// File: rtl/sprite_pixel_loader.sv
// Sprite pixel loader: accepts a raster stream of RGB888 pixels after a
// start request, packs them to RGB565 and writes them to consecutive
// addresses of an on-chip sprite memory starting at base_addr.
// Optional feature: SPRITE_KEY_NORMALIZE_EN (see rgb565_pack).
module sprite_pixel_loader
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [23:0]       in_rgb,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done
);

  localparam int PIXELS = SPRITE_W * SPRITE_H;
  localparam int IDX_W  = $clog2(PIXELS) + 1;

  load_state_e       state;
  load_state_e       next_state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       packed_pix;
  logic              start_ok;
  logic              accept;
  logic              last_accept;

  assign start_ok    = (state == ST_IDLE) && start;
  assign accept      = (state == ST_LOAD) && in_valid;
  assign last_accept = accept && (idx == IDX_W'(PIXELS - 1));

  rgb565_pack u_pack (
    .rgb    (in_rgb),
    .rgb565 (packed_pix)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic: start only matters in IDLE; FINISH lasts one cycle.
  // NOTE: next_state gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (start)       next_state = ST_LOAD;
      ST_LOAD:   if (last_accept) next_state = ST_FINISH;
      ST_FINISH:                  next_state = ST_IDLE;
      default:                    next_state = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE:   ;
      ST_LOAD:   begin in_ready = 1'b1; busy = 1'b1; end
      ST_FINISH: begin busy = 1'b1; done = 1'b1; end
      default:   ;
    endcase
  end

  // Pixel index and latched base: cleared/captured on start, step on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      base_q <= '0;
    end else if (start_ok) begin
      idx    <= '0;
      base_q <= base_addr;
    end else if (accept) begin
      idx    <= idx + IDX_W'(1);
    end
  end

  // Registered write port: one write per accepted pixel, one cycle later.
  // Address wraps naturally in ADDR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= base_q + ADDR_W'(idx);
        wr_data <= packed_pix;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pixel_loader.sv
// Self-checking bench for sprite_pixel_loader (default parameters).
// Expected writes are queued when pixels are driven and compared when the
// DUT's write strobe appears. Honours SPRITE_KEY_NORMALIZE_EN if defined.
module tb_sprite_pixel_loader;

  localparam int AW   = 10;
  localparam int NPIX = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic [23:0]   in_rgb = '0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          done;

  sprite_pixel_loader #(
    .SPRITE_W (32),
    .SPRITE_H (32),
    .ADDR_W   (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_rgb    (in_rgb),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          last;
  } wr_t;

  wr_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side model of the loader.
  bit            m_loading = 1'b0;
  int            m_idx     = 0;
  logic [AW-1:0] m_base    = '0;
  bit            start_req = 1'b0;
  logic [AW-1:0] start_base = '0;
  bit            mon_en    = 1'b0;
  bit            prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_pack(input logic [23:0] p);
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [15:0] v;
    r = p[23:16];
    g = p[15:8];
    b = p[7:0];
    v = {r[7:3], g[7:2], b[7:3]};
`ifdef SPRITE_KEY_NORMALIZE_EN
    if (p == 24'hFFFFFF ||
        (r >= 8'hD8 && g >= 8'h90 && g <= 8'hB4 && b >= 8'hA8 && b <= 8'hCC))
      v = 16'hF81F;
`endif
    return v;
  endfunction

  // Random pixels with a bias towards white and the pink range.
  function automatic logic [23:0] gen_pixel();
    logic [23:0] p;
    case ($urandom_range(0, 7))
      0:       p = 24'hFFFFFF;
      1:       p = {8'($urandom_range(8'hD8, 8'hFF)),
                    8'($urandom_range(8'h90, 8'hB4)),
                    8'($urandom_range(8'hA8, 8'hCC))};
      2:       p = {8'($urandom_range(8'hD8, 8'hFF)),
                    8'($urandom_range(8'h8E, 8'hB6)),
                    8'($urandom_range(8'hA6, 8'hCE))};
      default: p = 24'($urandom());
    endcase
    return p;
  endfunction

  // Drive one cycle of stimulus; inputs change just after the falling edge.
  task automatic drive_full(input logic valid, input logic [23:0] rgb, input logic [15:0] exp_data);
    bit was_loading;
    @(negedge clk);
    #1;
    check("in_ready", in_ready, m_loading);
    start     = start_req;
    base_addr = start_base;
    start_req = 1'b0;
    in_valid  = valid;
    in_rgb    = rgb;
    was_loading = m_loading;
    if (valid && m_loading) begin
      sb.push_back('{addr: m_base + AW'(m_idx), data: exp_data, last: (m_idx == NPIX - 1)});
      m_idx++;
      if (m_idx == NPIX) m_loading = 1'b0;
    end
    if (start && !was_loading) begin
      m_loading = 1'b1;
      m_base    = base_addr;
      m_idx     = 0;
    end
  endtask

  task automatic drive_px(input logic valid, input logic [23:0] rgb);
    drive_full(valid, rgb, exp_pack(rgb));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) drive_full(1'b0, 24'h0, 16'h0);
  endtask

  task automatic kick(input logic [AW-1:0] b);
    start_req  = 1'b1;
    start_base = b;
    idle_cycles(1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"},    wr_en,    0);
    check({tag, "_wr_addr"},  wr_addr,  0);
    check({tag, "_wr_data"},  wr_data,  0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      if (prev_done) check("busy_after_done", busy, 0);
      if (wr_en) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = sb.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
          check("done_with_write", done, e.last);
          if (e.last) check("busy_at_done", busy, 1);
        end
      end else begin
        check("done_without_write", done, 0);
      end
      prev_done = done;
    end
  end

  initial begin
    // Reset state.
    #3;
    check_outputs_zero("reset");
    @(negedge clk);
    #2 rst = 1'b0;
    mon_en = 1'b1;
    idle_cycles(2);

    // Full sprite at 0x100 with valid held high; wraps to 0x0FF.
    // A start mid-load must be ignored.
    kick(10'h100);
`ifdef SPRITE_KEY_NORMALIZE_EN
    drive_full(1'b1, 24'hFFAEC9, 16'hF81F);
`else
    drive_full(1'b1, 24'hFFAEC9, 16'hFD79);
`endif
    drive_full(1'b1, 24'h123456, 16'h11AA);
    for (int i = 2; i < NPIX; i++) begin
      if (i == 300) begin
        start_req  = 1'b1;
        start_base = 10'h200;
      end
      drive_px(1'b1, gen_pixel());
    end
    idle_cycles(4);
    check("fullA_drained", sb.size(), 0);
    check("fullA_idle_busy", busy, 0);

    // Valid toggling every cycle, base near the top of the address space.
    kick(10'h3F0);
    for (int i = 0; i < 2 * NPIX; i++) drive_px((i % 2) == 0, gen_pixel());
    idle_cycles(4);
    check("toggle_drained", sb.size(), 0);
    check("toggle_idle_busy", busy, 0);

    // Reset in the middle of a load, then restart from a new base.
    kick(10'h050);
    for (int i = 0; i < 500; i++) drive_px(1'b1, gen_pixel());
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    sb.delete();
    m_loading = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    idle_cycles(2);
    kick(10'h2A0);
    begin
      int budget;
      budget = 0;
      while (m_loading && budget < 4000) begin
        drive_px($urandom_range(0, 3) != 0, gen_pixel());
        budget++;
      end
      check("restart_load_finished", m_loading, 0);
    end
    idle_cycles(4);
    check("restart_drained", sb.size(), 0);
    check("restart_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
